mem_arbiter: RTL

- Sole owner of the byte-wide external RAM/IO port.
- Shares the port between two requesters:
  - the instruction cache, which fetches 64-bit blocks;
  - the load/store unit, which does 1/2/4-byte data accesses.
- Serialises each request into consecutive byte transfers and returns assembled data with a one-cycle valid pulse.
- Stalls IO-region writes while the IO buffer is full.

---
 rtl/mem_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: owns the byte-wide external RAM/IO port and shares it between
// the instruction cache (8-byte block fetches) and the load/store unit
// (1/2/4-byte accesses). Each request is serialised into byte transfers.
module mem_arbiter #(
   parameter logic [1:0] IO_TAG = 2'b11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        clear,
   input  logic        ic_en,
   input  logic [31:0] ic_addr,
   output logic        ic_valid,
   output logic [63:0] ic_blk,
   input  logic        ls_en,
   input  logic        ls_wr,
   input  logic [31:0] ls_addr,
   input  logic [1:0]  ls_len,
   input  logic [31:0] ls_wdata,
   output logic        ls_valid,
   output logic [31:0] ls_rdata,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t      state, state_n;
   logic        serve_ic, serve_ic_n;
   logic [31:0] base, base_n;
   logic [3:0]  nbytes, nbytes_n;
   logic [31:0] wdata, wdata_n;
   logic [3:0]  step, step_n;
   logic [63:0] rbuf, rbuf_n;
   logic [31:0] mem_a_n;
   logic [7:0]  mem_dout_n;
   logic        wr_q, wr_n;
   logic        ic_valid_n, ls_valid_n;
   logic [63:0] ic_blk_n;
   logic [31:0] ls_rdata_n;
   logic        launch;
   logic [2:0]  cap_idx;

   // Byte count for a load/store length code; code 3 behaves like a word.
   function automatic logic [3:0] len_bytes(input logic [1:0] len);
      case (len)
         2'd0:    len_bytes = 4'd1;
         2'd1:    len_bytes = 4'd2;
         default: len_bytes = 4'd4;
      endcase
   endfunction

   // Read data lags the address by two edges, so the byte landing at step k is byte k-2.
   assign cap_idx = 3'(step - 4'd2);

   // The write strobe is suppressed combinationally whenever the block is frozen.
   assign mem_wr = wr_q & rdy;

   // State and datapath registers: reset wins, otherwise advance only while rdy is high.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         serve_ic <= 1'b0;
         base     <= '0;
         nbytes   <= '0;
         wdata    <= '0;
         step     <= '0;
         rbuf     <= '0;
         mem_a    <= '0;
         mem_dout <= '0;
         wr_q     <= 1'b0;
         ic_valid <= 1'b0;
         ls_valid <= 1'b0;
         ic_blk   <= '0;
         ls_rdata <= '0;
      end else if (rdy) begin
         state    <= state_n;
         serve_ic <= serve_ic_n;
         base     <= base_n;
         nbytes   <= nbytes_n;
         wdata    <= wdata_n;
         step     <= step_n;
         rbuf     <= rbuf_n;
         mem_a    <= mem_a_n;
         mem_dout <= mem_dout_n;
         wr_q     <= wr_n;
         ic_valid <= ic_valid_n;
         ls_valid <= ls_valid_n;
         ic_blk   <= ic_blk_n;
         ls_rdata <= ls_rdata_n;
      end
   end

   // Next-state and datapath: arbitration in IDLE, byte sequencing in RD/WR, one-cycle DONE.
   always_comb begin
      state_n    = state;
      serve_ic_n = serve_ic;
      base_n     = base;
      nbytes_n   = nbytes;
      wdata_n    = wdata;
      step_n     = step;
      rbuf_n     = rbuf;
      mem_a_n    = mem_a;
      mem_dout_n = mem_dout;
      wr_n       = 1'b0;
      ic_valid_n = 1'b0;
      ls_valid_n = 1'b0;
      ic_blk_n   = ic_blk;
      ls_rdata_n = ls_rdata;
      launch     = 1'b0;

      case (state)
         IDLE: begin
            if (ls_en) begin
               serve_ic_n = 1'b0;
               base_n     = ls_addr;
               nbytes_n   = len_bytes(ls_len);
               wdata_n    = ls_wdata;
               rbuf_n     = '0;
               step_n     = 4'd0;
               if (ls_wr) begin
                  state_n = WR;
                  launch  = 1'b1;
               end else begin
                  state_n = RD;
                  mem_a_n = ls_addr;
                  step_n  = 4'd1;
               end
            end else if (ic_en && !clear) begin
               serve_ic_n = 1'b1;
               base_n     = ic_addr;
               nbytes_n   = 4'd8;
               rbuf_n     = '0;
               state_n    = RD;
               mem_a_n    = ic_addr;
               step_n     = 4'd1;
            end
         end
         RD: begin
            if (serve_ic && clear) begin
               state_n = IDLE;
               mem_a_n = '0;
            end else begin
               if (step < nbytes) begin
                  mem_a_n = base + {28'd0, step};
               end
               if (step >= 4'd2) begin
                  rbuf_n[{cap_idx, 3'b000} +: 8] = mem_din;
               end
               if (step == nbytes + 4'd1) begin
                  state_n = DONE;
                  if (serve_ic) begin
                     ic_blk_n   = rbuf_n;
                     ic_valid_n = 1'b1;
                  end else begin
                     ls_rdata_n = rbuf_n[31:0];
                     ls_valid_n = 1'b1;
                  end
               end
               step_n = step + 4'd1;
            end
         end
         WR: begin
            if (step == nbytes) begin
               ls_valid_n = 1'b1;
               state_n    = DONE;
            end else begin
               launch = 1'b1;
            end
         end
         DONE: begin
            state_n = IDLE;
            mem_a_n = '0;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      if (launch && !(base_n[17:16] == IO_TAG && io_buffer_full)) begin
         mem_a_n    = base_n + {28'd0, step_n};
         mem_dout_n = wdata_n[{step_n[1:0], 3'b000} +: 8];
         wr_n       = 1'b1;
         step_n     = step_n + 4'd1;
      end
   end

endmodule
